// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow finish in one cycle.
module exu_div #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_src1,
  input  logic [DATA_WIDTH-1:0] i_src2,
  input  logic                  i_signed,
  input  logic                  i_sel_rem,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_div_dout
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_TOP = CNT_WIDTH'(DATA_WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;     // dividend, becomes quotient
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [DATA_WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  negq_q, negq_d;   // negate quotient in FIX
  logic                  negr_q, negr_d;   // negate remainder in FIX
  logic                  sel_rem_q, sel_rem_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic                  s1, s2;
  logic [DATA_WIDTH:0]   trial, diff;
  logic [DATA_WIDTH-1:0] q_fix, r_fix;

  // Operand signs, one restoring step, and final sign correction.
  always_comb begin
    s1    = i_signed & i_src1[DATA_WIDTH-1];
    s2    = i_signed & i_src2[DATA_WIDTH-1];
    trial = {rem_q, dvd_q[DATA_WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    q_fix = negq_q ? (DATA_WIDTH'(0) - dvd_q) : dvd_q;
    r_fix = negr_q ? (DATA_WIDTH'(0) - rem_q) : rem_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    sel_rem_d = sel_rem_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_start && !i_flush) begin
          sel_rem_d = i_sel_rem;
          dvd_d     = s1 ? (DATA_WIDTH'(0) - i_src1) : i_src1;
          dvs_d     = s2 ? (DATA_WIDTH'(0) - i_src2) : i_src2;
          negq_d    = s1 ^ s2;
          negr_d    = s1;
          rem_d     = '0;
          cnt_d     = CNT_TOP;
          if (i_src2 == '0) begin
            dout_d  = i_sel_rem ? i_src1 : '1;
            state_d = S_DONE;
            valid_d = 1'b1;
          end else if (i_signed && (i_src1 == MIN_NEG) && (i_src2 == '1)) begin
            dout_d  = i_sel_rem ? '0 : MIN_NEG;
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = diff[DATA_WIDTH] ? trial[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
          dvd_d  = {dvd_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
          busy_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
      end
      S_FIX: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          dout_d  = sel_rem_q ? r_fix : q_fix;
          state_d = S_DONE;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      sel_rem_q <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      sel_rem_q <= sel_rem_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_div_dout = dout_q;

endmodule

// File: tb/tb_exu_div.sv
// Directed self-checking bench for exu_div.
module tb_exu_div;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_flush;
  logic [31:0] i_src1;
  logic [31:0] i_src2;
  logic        i_signed;
  logic        i_sel_rem;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_div_dout;

  int nvec  = 0;
  int nfail = 0;

  exu_div dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_flush    (i_flush),
    .i_src1     (i_src1),
    .i_src2     (i_src2),
    .i_signed   (i_signed),
    .i_sel_rem  (i_sel_rem),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_div_dout (o_div_dout)
  );

  always #5 i_clk = ~i_clk;

  // Launch one op, scramble operands after the sampling edge, wait for o_valid.
  // lat = cycle (1 = cycle after the sampling edge) in which o_valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic rm, output logic [31:0] res, output int lat,
                        output int busy_cycles, output logic busy_at_valid);
    @(negedge i_clk);
    i_src1 = a; i_src2 = b; i_signed = sg; i_sel_rem = rm; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_src1 = $urandom; i_src2 = $urandom;
    i_signed = ~sg; i_sel_rem = ~rm;
    lat = 1; busy_cycles = 0;
    while (!o_valid && lat < 100) begin
      if (o_busy) busy_cycles++;
      @(posedge i_clk); #1;
      lat++;
    end
    res = o_div_dout;
    busy_at_valid = o_busy;
  endtask

  // Start an op and advance to the given cycle after the sampling edge.
  task automatic launch_to(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input logic rm, input int cyc);
    @(negedge i_clk);
    i_src1 = a; i_src2 = b; i_signed = sg; i_sel_rem = rm; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (cyc - 1) begin @(posedge i_clk); #1; end
  endtask

  // Count o_valid pulses over a window of cycles.
  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin @(posedge i_clk); #1; if (o_valid) seen++; end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 0; i_flush = 0; i_src1 = 0; i_src2 = 0;
    i_signed = 0; i_sel_rem = 0;
    #12;
    nvec++;
    if ({o_busy, o_valid, o_div_dout} !== 34'd0) begin
      nfail++; $display("FAIL reset_outputs: got busy=%b valid=%b dout=%h want 0/0/0", o_busy, o_valid, o_div_dout);
    end
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
    nvec++;
    if ({o_busy, o_valid, o_div_dout} !== 34'd0) begin
      nfail++; $display("FAIL idle_after_reset: got busy=%b valid=%b dout=%h want 0/0/0", o_busy, o_valid, o_div_dout);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic        rm;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic test_arith;
    vec_t v[15];
    logic [31:0] r; int l, bc; logic bv;
    v[0]  = '{32'd20,        32'd3,          1, 0, 32'd6,          34, "div_20_3"};
    v[1]  = '{32'd20,        32'd3,          1, 1, 32'd2,          34, "rem_20_3"};
    v[2]  = '{32'hFFFFFFF9,  32'd2,          1, 0, 32'hFFFFFFFD,   34, "div_m7_2"};
    v[3]  = '{32'hFFFFFFF9,  32'd2,          1, 1, 32'hFFFFFFFF,   34, "rem_m7_2"};
    v[4]  = '{32'd7,         32'hFFFFFFFE,   1, 1, 32'd1,          34, "rem_7_m2"};
    v[5]  = '{32'd7,         32'hFFFFFFFE,   1, 0, 32'hFFFFFFFD,   34, "div_7_m2"};
    v[6]  = '{32'hFFFFFFFF,  32'd1,          0, 0, 32'hFFFFFFFF,   34, "divu_max_1"};
    v[7]  = '{32'hFFFFFFFF,  32'h10,         0, 1, 32'hF,          34, "remu_max_16"};
    v[8]  = '{32'd100,       32'd7,          0, 0, 32'd14,         34, "divu_100_7"};
    v[9]  = '{32'd100,       32'd7,          0, 1, 32'd2,          34, "remu_100_7"};
    v[10] = '{32'd5,         32'd0,          1, 0, 32'hFFFFFFFF,   1,  "div_by_zero"};
    v[11] = '{32'd5,         32'd0,          0, 1, 32'd5,          1,  "remu_by_zero"};
    v[12] = '{32'h80000000,  32'hFFFFFFFF,   1, 0, 32'h80000000,   1,  "div_overflow"};
    v[13] = '{32'h80000000,  32'hFFFFFFFF,   1, 1, 32'd0,          1,  "rem_overflow"};
    v[14] = '{32'h80000000,  32'hFFFFFFFF,   0, 0, 32'd0,          34, "divu_min_max"};
    for (int i = 0; i < 15; i++) begin
      run_op(v[i].a, v[i].b, v[i].sg, v[i].rm, r, l, bc, bv);
      nvec++;
      if (r !== v[i].exp) begin
        nfail++; $display("FAIL %s result: got %h want %h", v[i].name, r, v[i].exp);
      end
      nvec++;
      if (l !== v[i].lat) begin
        nfail++; $display("FAIL %s latency: got %0d want %0d", v[i].name, l, v[i].lat);
      end
      nvec++;
      if (bc !== ((v[i].lat == 34) ? 33 : 0)) begin
        nfail++; $display("FAIL %s busy_cycles: got %0d want %0d", v[i].name, bc, (v[i].lat == 34) ? 33 : 0);
      end
      nvec++;
      if (bv !== 1'b0) begin
        nfail++; $display("FAIL %s busy_in_done: got %b want 0", v[i].name, bv);
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] r; int l, bc, seen; logic bv;
    run_op(32'd20, 32'd3, 1, 0, r, l, bc, bv);
    nvec++;
    if (r !== 32'd6) begin nfail++; $display("FAIL flush_pre: got %h want %h", r, 32'd6); end
    launch_to(32'd100, 32'd7, 0, 0, 10);
    @(negedge i_clk); i_flush = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0; i_start = 1'b0;
    nvec++;
    if ({o_busy, o_valid} !== 2'b00) begin
      nfail++; $display("FAIL flush_calc_state: got busy=%b valid=%b want 0/0", o_busy, o_valid);
    end
    count_valid(40, seen);
    nvec++;
    if (seen !== 0) begin nfail++; $display("FAIL flush_no_valid: got %0d pulses want 0", seen); end
    nvec++;
    if (o_div_dout !== 32'd6) begin nfail++; $display("FAIL flush_dout_hold: got %h want %h", o_div_dout, 32'd6); end
    // Flush and start together in IDLE: nothing launches.
    @(negedge i_clk); i_src1 = 32'd20; i_src2 = 32'd3; i_signed = 1; i_sel_rem = 1;
    i_flush = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0; i_start = 1'b0;
    nvec++;
    if (o_busy !== 1'b0) begin nfail++; $display("FAIL flush_start_busy: got %b want 0", o_busy); end
    count_valid(40, seen);
    nvec++;
    if (seen !== 0) begin nfail++; $display("FAIL flush_start_valid: got %0d pulses want 0", seen); end
  endtask

  task automatic test_busy_ignore;
    int l, seen;
    launch_to(32'd100, 32'd7, 0, 0, 5);
    @(negedge i_clk);
    i_src1 = 32'd20; i_src2 = 32'd3; i_signed = 1; i_sel_rem = 1; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    l = 6;
    while (!o_valid && l < 100) begin @(posedge i_clk); #1; l++; end
    nvec++;
    if (l !== 34) begin nfail++; $display("FAIL ignore_latency: got %0d want 34", l); end
    nvec++;
    if (o_div_dout !== 32'd14) begin nfail++; $display("FAIL ignore_result: got %h want %h", o_div_dout, 32'd14); end
    count_valid(40, seen);
    nvec++;
    if (seen !== 0) begin nfail++; $display("FAIL ignore_no_second: got %0d pulses want 0", seen); end
  endtask

  task automatic test_async_reset;
    int seen;
    launch_to(32'd100, 32'd7, 0, 1, 10);
    #2 i_rst = 1'b1;
    #1;
    nvec++;
    if ({o_busy, o_valid, o_div_dout} !== 34'd0) begin
      nfail++; $display("FAIL async_reset: got busy=%b valid=%b dout=%h want 0/0/0", o_busy, o_valid, o_div_dout);
    end
    @(negedge i_clk); i_rst = 1'b0;
    count_valid(40, seen);
    nvec++;
    if (seen !== 0) begin nfail++; $display("FAIL reset_no_valid: got %0d pulses want 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int l, bc; logic bv;
    run_op(32'd20, 32'd3, 1, 0, r, l, bc, bv);
    nvec++;
    if (r !== 32'd6) begin nfail++; $display("FAIL b2b_first: got %h want %h", r, 32'd6); end
    // Still inside the DONE cycle: launch the second op.
    i_src1 = 32'hFFFFFFF9; i_src2 = 32'd2; i_signed = 1; i_sel_rem = 1; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0; i_src1 = 32'd0; i_src2 = 32'd0;
    l = 1;
    while (!o_valid && l < 100) begin @(posedge i_clk); #1; l++; end
    nvec++;
    if (l !== 34) begin nfail++; $display("FAIL b2b_latency: got %0d want 34", l); end
    nvec++;
    if (o_div_dout !== 32'hFFFFFFFF) begin
      nfail++; $display("FAIL b2b_second: got %h want %h", o_div_dout, 32'hFFFFFFFF);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_flush();
    test_busy_ignore();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
